// File: rtl/audio_echo_path_if.sv
// rtl/audio_echo_path_if.sv - sample strobe, mode controls and processed-output bundle for audio_echo_path
interface audio_echo_path_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic                     new_sample;
  logic [NUM_CH*DATA_W-1:0] line_in;
  logic [1:0]               mode;
  logic [2:0]               fb_shift;
  logic [NUM_CH*DATA_W-1:0] hphone_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  // Sample source / control side
  modport master (
    output new_sample, line_in, mode, fb_shift,
    input  hphone_out, out_valid, busy, overrun
  );

  // Echo path side
  modport slave (
    input  new_sample, line_in, mode, fb_shift,
    output hphone_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/audio_echo_path.sv
// rtl/audio_echo_path.sv - per-channel bypass/mute/delay/echo processor over a cleared delay-line RAM
module audio_echo_path #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input logic             clk,
  input logic             rst,
  audio_echo_path_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = CH_W + DEPTH_LOG2;
  localparam int WORDS = NUM_CH << DEPTH_LOG2;

  localparam logic [AW-1:0]     LAST_ADDR = AW'(WORDS - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] SAT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {CLEAR, IDLE, RD, CALC, DONE} state_t;

  state_t state;
  state_t state_next;

  // Delay line: one 2^DEPTH_LOG2 ring per channel, channel in the address MSBs
  logic [DATA_W-1:0] mem [WORDS];

  logic [AW-1:0]            clear_addr;
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [CH_W-1:0]          ch;
  logic [AW-1:0]            frame_addr;
  logic [NUM_CH*DATA_W-1:0] x_reg;
  logic [1:0]               mode_reg;
  logic [2:0]               fb_reg;
  logic [NUM_CH*DATA_W-1:0] staging;
  logic [NUM_CH*DATA_W-1:0] staging_next;
  logic [NUM_CH*DATA_W-1:0] hphone_reg;
  logic                     out_valid_reg;
  logic                     overrun_reg;

  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [DATA_W-1:0] d_shift;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] wr_data;
  logic        [DATA_W:0]   sum;

  assign frame_addr     = {ch, wr_ptr};
  assign bus.hphone_out = hphone_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.busy       = (state != IDLE);

  // State register; reset always restarts the full buffer clear
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Next-state logic: clear sweep, then one RD/CALC pair per channel per frame
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clear_addr == LAST_ADDR) state_next = IDLE;
      IDLE:  if (bus.new_sample) state_next = RD;
      RD:    state_next = CALC;
      CALC:  state_next = (ch == LAST_CH) ? DONE : RD;
      DONE:  state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // Per-channel arithmetic: select output and the value fed back into the ring
  always_comb begin
    x_cur   = x_reg[ch*DATA_W +: DATA_W];
    d_shift = rd_data >>> fb_reg;
    sum     = {x_cur[DATA_W-1], x_cur} + {d_shift[DATA_W-1], d_shift};
    y       = x_cur;
    wr_data = x_cur;
    case (mode_reg)
      2'b00: y = x_cur;
      2'b01: y = '0;
      2'b10: y = rd_data;
      default: begin
        // Overflow shows up as the two top bits of the widened sum disagreeing
        if (sum[DATA_W] != sum[DATA_W-1]) y = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        else                              y = sum[DATA_W-1:0];
        wr_data = y;
      end
    endcase
    staging_next = staging;
    staging_next[ch*DATA_W +: DATA_W] = y;
  end

  // Delay-line RAM: single write port shared by the clear sweep and CALC, registered read in RD
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)     mem[clear_addr] <= '0;
      else if (state == CALC) mem[frame_addr] <= wr_data;
    end
    if (state == RD) rd_data <= mem[frame_addr];
  end

  // Frame datapath: capture, per-channel staging, output publish and pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_addr    <= '0;
      wr_ptr        <= '0;
      ch            <= '0;
      x_reg         <= '0;
      mode_reg      <= '0;
      fb_reg        <= '0;
      staging       <= '0;
      hphone_reg    <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (bus.new_sample && state != IDLE) overrun_reg <= 1'b1;
      case (state)
        CLEAR: clear_addr <= clear_addr + 1'b1;
        IDLE: begin
          if (bus.new_sample) begin
            x_reg    <= bus.line_in;
            mode_reg <= bus.mode;
            fb_reg   <= bus.fb_shift;
            ch       <= '0;
          end
        end
        CALC: begin
          staging <= staging_next;
          if (ch == LAST_CH) begin
            // Loaded on the edge into DONE so the output and strobe are visible during DONE
            hphone_reg    <= staging_next;
            out_valid_reg <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DONE: wr_ptr <= wr_ptr + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_echo_path.sv
// tb/tb_audio_echo_path.sv - self-checking bench for audio_echo_path with a queue-based delay-line model
module tb_audio_echo_path;
  localparam int DW = 16;
  localparam int NC = 2;
  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_echo_path_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();

  audio_echo_path #(.DATA_W(DW), .NUM_CH(NC), .DEPTH_LOG2(DL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Each channel's delay line is a FIFO of the last DEPTH values written back
  int hist0[$];
  int hist1[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist0.delete();
    hist1.delete();
    for (int i = 0; i < DEPTH; i++) begin
      hist0.push_back(0);
      hist1.push_back(0);
    end
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [31:0] model_frame(input logic [31:0] lin, input logic [1:0] m, input logic [2:0] fs);
    logic [31:0] res;
    int x, d, y, w;
    res = '0;
    for (int c = 0; c < NC; c++) begin
      x = $signed(lin[c*16 +: 16]);
      d = (c == 0) ? hist0.pop_front() : hist1.pop_front();
      case (m)
        2'd0:    begin y = x; w = x; end
        2'd1:    begin y = 0; w = x; end
        2'd2:    begin y = d; w = x; end
        default: begin y = sat16(x + (d >>> fs)); w = y; end
      endcase
      res[c*16 +: 16] = y[15:0];
      if (c == 0) hist0.push_back(w);
      else        hist1.push_back(w);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.new_sample = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_hphone", bus.hphone_out, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] lin, input logic [1:0] m,
                           input logic [2:0] fs, input bit scramble, output logic [31:0] got);
    logic [31:0] exp;
    int lat;
    exp = model_frame(lin, m, fs);
    bus.line_in    = lin;
    bus.mode       = m;
    bus.fb_shift   = fs;
    bus.new_sample = 1'b1;
    tick();
    bus.new_sample = 1'b0;
    if (scramble) begin
      bus.mode     = 2'($urandom_range(3));
      bus.fb_shift = 3'($urandom_range(7));
      bus.line_in  = $urandom;
    end
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = bus.hphone_out;
    check({tag, "_lat"}, lat, 5);
    check({tag, "_out"}, got, exp);
    tick();
    check({tag, "_hold"}, bus.hphone_out, exp);
    check({tag, "_pulse"}, bus.out_valid, 0);
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    logic [31:0] lin;
    int exp_l, exp_r, cnt, gap;

    bus.new_sample = 1'b0;
    bus.line_in    = '0;
    bus.mode       = 2'd0;
    bus.fb_shift   = 3'd0;

    // Reset, clear sweep length, then a delay frame sees only cleared data
    do_reset();
    wait_idle("clear_len", 8);
    run_frame("idle_delay", 32'h5A5A_A5A5, 2'd2, 3'd0, 1'b0, got);
    check("idle_delay_zero", got, 32'h0);

    // Bypass
    run_frame("bypass", 32'hFEDC_1234, 2'd0, 3'd0, 1'b0, got);
    check("bypass_val", got, 32'hFEDC_1234);

    // Delay across the pointer wrap
    do_reset();
    wait_idle("clear_len2", 8);
    for (int i = 1; i <= 6; i++) begin
      run_frame("delay", {16'(100 + i), 16'(i)}, 2'd2, 3'd0, 1'b0, got);
      exp_l = (i > DEPTH) ? i - DEPTH : 0;
      exp_r = (i > DEPTH) ? 100 + i - DEPTH : 0;
      check("delay_l", got[15:0], exp_l);
      check("delay_r", got[31:16], exp_r);
    end

    // Echo saturation, with controls changing mid-frame
    do_reset();
    wait_idle("clear_len3", 8);
    for (int i = 0; i < 5; i++)
      run_frame("echo", 32'h9000_7000, 2'd3, 3'd0, 1'b1, got);
    check("echo_sat_l", got[15:0], 16'h7FFF);
    check("echo_sat_r", got[31:16], 16'h8000);

    // Overrun: second strobe two cycles after the first
    do_reset();
    wait_idle("clear_len4", 8);
    lin = 32'h0BAD_0F00;
    exp = model_frame(lin, 2'd0, 3'd0);
    bus.line_in = lin; bus.mode = 2'd0; bus.fb_shift = 3'd0;
    bus.new_sample = 1'b1;
    tick();
    bus.new_sample = 1'b0;
    cnt = 0;
    tick();
    bus.new_sample = 1'b1;
    bus.line_in = 32'h1111_2222;
    tick();
    bus.new_sample = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    check("ovr_valid_count", cnt, 1);
    check("ovr_flag", bus.overrun, 1);
    check("ovr_out", bus.hphone_out, exp);
    run_frame("ovr_next", 32'h0001_0002, 2'd0, 3'd0, 1'b0, got);
    check("ovr_sticky", bus.overrun, 1);

    // Strobe during the clear sweep is dropped
    do_reset();
    bus.line_in = 32'h7777_7777;
    bus.new_sample = 1'b1;
    tick();
    bus.new_sample = 1'b0;
    wait_idle("clear_strobe_len", 7);
    check("clear_overrun", bus.overrun, 1);
    run_frame("clear_delay", 32'h0, 2'd2, 3'd0, 1'b0, got);
    check("clear_delay_zero", got, 32'h0);

    // Mid-frame reset in the CALC cycle
    run_frame("pre_abort", 32'h4321_8765, 2'd0, 3'd0, 1'b0, got);
    bus.line_in = 32'h3333_4444; bus.mode = 2'd0;
    bus.new_sample = 1'b1;
    tick();
    bus.new_sample = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("abort_valid", bus.out_valid, 0);
    check("abort_hphone", bus.hphone_out, 0);
    check("abort_overrun", bus.overrun, 0);
    cnt = 0;
    gap = 0;
    while (bus.busy && gap < 50) begin
      tick();
      gap++;
      if (bus.out_valid) cnt++;
    end
    check("abort_busy_len", gap, 8);
    check("abort_no_valid", cnt, 0);
    run_frame("abort_delay", 32'h0, 2'd2, 3'd0, 1'b0, got);
    check("abort_delay_zero", got, 32'h0);

    // Randomized frames against the model, with idle gaps checking output hold
    do_reset();
    wait_idle("clear_len5", 8);
    for (int i = 0; i < 40; i++) begin
      run_frame("rand", $urandom, 2'($urandom_range(3)), 3'($urandom_range(7)), 1'b1, got);
      gap = $urandom_range(3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("rand_gap_hold", bus.hphone_out, got);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
